// File: rtl/mario_motion_ctrl.sv
// Mario sprite motion controller: turns the PIO command word into per-frame
// walking and jump/gravity updates for the sprite renderer.
module mario_motion_ctrl #(
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = 608,
  parameter int unsigned X_START  = 64,
  parameter int unsigned Y_GROUND = 400,
  parameter int unsigned STEP_X   = 2,
  parameter int unsigned JUMP_V   = 12,
  parameter int unsigned GRAVITY  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cmd_word,
  input  logic        frame_tick,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        facing_left,
  output logic [1:0]  motion_state,
  output logic        update_valid
);

  localparam int unsigned CMD_W = 4;
  localparam int unsigned XS_W  = 11;
  localparam int unsigned YS_W  = 12;
  localparam int unsigned VY_W  = 8;

  localparam logic signed [XS_W-1:0] X_MIN_S  = XS_W'(X_MIN);
  localparam logic signed [XS_W-1:0] X_MAX_S  = XS_W'(X_MAX);
  localparam logic signed [XS_W-1:0] STEP_S   = XS_W'(STEP_X);
  localparam logic signed [YS_W-1:0] Y_GND_S  = YS_W'(Y_GROUND);
  localparam logic signed [VY_W-1:0] JUMP_S   = VY_W'(JUMP_V);
  localparam logic signed [VY_W-1:0] GRAV_S   = VY_W'(GRAVITY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_AIR  = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [CMD_W-1:0]       cmd_q;
  logic                   jump_prev;
  logic                   jump_req, jump_req_nxt;
  logic signed [VY_W-1:0] vy, vy_nxt;
  logic [9:0]             x_nxt, y_nxt;
  logic                   face_nxt;

  logic                   dir_l, dir_r, one_dir, jump_edge;
  state_t                 ground_st;
  logic signed [XS_W-1:0] x_s, x_left, x_right;
  logic signed [YS_W-1:0] y_s, vy_w, y_new;
  logic signed [VY_W-1:0] vy_dec;

  // Reserved command bits are intentionally dropped.
  logic unused_rsvd;
  assign unused_rsvd = ^cmd_word[31:CMD_W];

  assign motion_state = state;

  // State register: command capture, jump edge tracking and per-frame physics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cmd_q        <= '0;
      jump_prev    <= 1'b0;
      jump_req     <= 1'b0;
      vy           <= '0;
      pos_x        <= 10'(X_START);
      pos_y        <= 10'(Y_GROUND);
      facing_left  <= 1'b0;
      update_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      cmd_q        <= cmd_word[CMD_W-1:0];
      jump_prev    <= cmd_q[2];
      jump_req     <= jump_req_nxt;
      vy           <= vy_nxt;
      pos_x        <= x_nxt;
      pos_y        <= y_nxt;
      facing_left  <= face_nxt;
      update_valid <= frame_tick;
    end
  end

  // Next-state and physics evaluation.
  always_comb begin
    state_nxt    = state;
    jump_req_nxt = jump_req;
    vy_nxt       = vy;
    x_nxt        = pos_x;
    y_nxt        = pos_y;
    face_nxt     = facing_left;

    dir_l     = cmd_q[0];
    dir_r     = cmd_q[1];
    one_dir   = dir_l ^ dir_r;
    jump_edge = cmd_q[2] & ~jump_prev;
    ground_st = one_dir ? ST_WALK : ST_IDLE;

    x_s     = XS_W'({1'b0, pos_x});
    x_left  = x_s - STEP_S;
    x_right = x_s + STEP_S;
    y_s     = YS_W'({2'b00, pos_y});
    vy_w    = {{(YS_W-VY_W){vy[VY_W-1]}}, vy};
    y_new   = y_s - vy_w;
    vy_dec  = vy - GRAV_S;

    if (frame_tick) begin
      jump_req_nxt = 1'b0;
      if (cmd_q[3]) begin
        x_nxt     = 10'(X_START);
        y_nxt     = 10'(Y_GROUND);
        vy_nxt    = '0;
        state_nxt = ST_IDLE;
      end else begin
        if (dir_l && !dir_r) begin
          x_nxt    = (x_left < X_MIN_S) ? 10'(X_MIN_S) : 10'(x_left);
          face_nxt = 1'b1;
        end else if (dir_r && !dir_l) begin
          x_nxt    = (x_right > X_MAX_S) ? 10'(X_MAX_S) : 10'(x_right);
          face_nxt = 1'b0;
        end

        case (state)
          ST_IDLE, ST_WALK: begin
            if (jump_req) begin
              vy_nxt    = JUMP_S;
              state_nxt = ST_AIR;
            end else begin
              state_nxt = ground_st;
            end
          end
          ST_AIR: begin
            if (y_new >= Y_GND_S) begin
              y_nxt     = 10'(Y_GND_S);
              vy_nxt    = '0;
              state_nxt = ground_st;
            end else if (y_new < 0) begin
              y_nxt  = '0;
              vy_nxt = '0;
            end else begin
              y_nxt  = 10'(y_new);
              vy_nxt = (vy_dec < -JUMP_S) ? -JUMP_S : vy_dec;
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end

    // An edge arriving with a tick is kept for the following tick; edges in the air are dropped.
    if (jump_edge && state != ST_AIR && state_nxt != ST_AIR && !(frame_tick && cmd_q[3]))
      jump_req_nxt = 1'b1;
  end

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Directed self-checking bench for mario_motion_ctrl.
module tb_mario_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cmd_word;
  logic        frame_tick;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        facing_left;
  logic [1:0]  motion_state;
  logic        update_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WALK = 2'd1;
  localparam logic [1:0] AIR  = 2'd2;

  mario_motion_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_word     (cmd_word),
    .frame_tick   (frame_tick),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .facing_left  (facing_left),
    .motion_state (motion_state),
    .update_valid (update_valid)
  );

  always #5 clk = ~clk;

  // One frame: pulse frame_tick for a cycle, return at the negedge after the update edge.
  task automatic do_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_jump();
    @(negedge clk) cmd_word = 32'h4;
    idle_cycles(2);
    cmd_word = 32'h0;
    idle_cycles(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_word = 32'h0; frame_tick = 1'b0;
    idle_cycles(2);
    checks++;
    if (pos_x !== 10'd64 || pos_y !== 10'd400 || motion_state !== IDLE ||
        facing_left !== 1'b0 || update_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: x=%0d y=%0d st=%0d f=%0b uv=%0b, want 64 400 0 0 0",
               pos_x, pos_y, motion_state, facing_left, update_valid);
    end
    @(negedge clk) reset_n = 1'b1;
    cmd_word = 32'hFFFF_FFF0;  // reserved bits only
    idle_cycles(2);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk) frame_tick = 1'b1;
      checks++;
      if (update_valid !== 1'b0) begin
        errors++; $display("FAIL uv_before_tick: uv=%0b want 0", update_valid);
      end
      @(negedge clk) frame_tick = 1'b0;
      checks++;
      if (update_valid !== 1'b1) begin
        errors++; $display("FAIL uv_pulse: uv=%0b want 1", update_valid);
      end
      @(negedge clk);
      checks++;
      if (update_valid !== 1'b0) begin
        errors++; $display("FAIL uv_one_cycle: uv=%0b want 0", update_valid);
      end
      checks++;
      if (pos_x !== 10'd64 || pos_y !== 10'd400 || motion_state !== IDLE) begin
        errors++;
        $display("FAIL idle_tick: x=%0d y=%0d st=%0d want 64 400 0", pos_x, pos_y, motion_state);
      end
    end
    cmd_word = 32'h0;
  endtask

  task automatic test_walk();
    @(negedge clk) cmd_word = 32'h2;
    for (int t = 0; t < 5; t++) do_tick();
    checks++;
    if (pos_x !== 10'd74 || facing_left !== 1'b0 || motion_state !== WALK) begin
      errors++;
      $display("FAIL walk_right: x=%0d f=%0b st=%0d want 74 0 1", pos_x, facing_left, motion_state);
    end
    @(negedge clk) cmd_word = 32'h3;
    for (int t = 0; t < 2; t++) do_tick();
    checks++;
    if (pos_x !== 10'd74 || motion_state !== IDLE || facing_left !== 1'b0) begin
      errors++;
      $display("FAIL both_dirs: x=%0d st=%0d f=%0b want 74 0 0", pos_x, motion_state, facing_left);
    end
  endtask

  task automatic test_left_clamp();
    @(negedge clk) cmd_word = 32'h8;
    do_tick();
    checks++;
    if (pos_x !== 10'd64 || motion_state !== IDLE) begin
      errors++; $display("FAIL repos_walk: x=%0d st=%0d want 64 0", pos_x, motion_state);
    end
    cmd_word = 32'h1;
    for (int t = 0; t < 31; t++) do_tick();
    checks++;
    if (pos_x !== 10'd2 || facing_left !== 1'b1 || motion_state !== WALK) begin
      errors++;
      $display("FAIL left_31: x=%0d f=%0b st=%0d want 2 1 1", pos_x, facing_left, motion_state);
    end
    do_tick();
    checks++;
    if (pos_x !== 10'd0) begin
      errors++; $display("FAIL left_32: x=%0d want 0", pos_x);
    end
    for (int t = 0; t < 8; t++) do_tick();
    checks++;
    if (pos_x !== 10'd0 || facing_left !== 1'b1) begin
      errors++; $display("FAIL left_hold: x=%0d f=%0b want 0 1", pos_x, facing_left);
    end
  endtask

  task automatic test_right_clamp();
    @(negedge clk) cmd_word = 32'h8;
    do_tick();
    cmd_word = 32'h2;
    for (int t = 0; t < 272; t++) do_tick();
    checks++;
    if (pos_x !== 10'd608 || facing_left !== 1'b0) begin
      errors++; $display("FAIL right_clamp: x=%0d f=%0b want 608 0", pos_x, facing_left);
    end
    do_tick();
    checks++;
    if (pos_x !== 10'd608) begin
      errors++; $display("FAIL right_hold: x=%0d want 608", pos_x);
    end
    @(negedge clk) cmd_word = 32'h8;
    do_tick();
    cmd_word = 32'h0;
  endtask

  task automatic test_jump();
    logic [9:0] y_exp;
    pulse_jump();
    do_tick();
    checks++;
    if (motion_state !== AIR || pos_y !== 10'd400) begin
      errors++; $display("FAIL jump_t1: st=%0d y=%0d want 2 400", motion_state, pos_y);
    end
    do_tick();
    checks++;
    if (pos_y !== 10'd388) begin
      errors++; $display("FAIL jump_t2: y=%0d want 388", pos_y);
    end
    y_exp = 10'd388;
    for (int t = 3; t <= 25; t++) begin
      do_tick();
      y_exp = (t <= 13) ? y_exp - 10'(14 - t) : y_exp + 10'(t - 14);
      checks++;
      if (pos_y !== y_exp || motion_state !== AIR) begin
        errors++;
        $display("FAIL jump_arc t%0d: y=%0d st=%0d want %0d 2", t, pos_y, motion_state, y_exp);
      end
    end
    do_tick();
    checks++;
    if (pos_y !== 10'd400 || motion_state !== IDLE || pos_x !== 10'd64) begin
      errors++;
      $display("FAIL land_t26: y=%0d st=%0d x=%0d want 400 0 64", pos_y, motion_state, pos_x);
    end
  endtask

  task automatic test_held_jump();
    pulse_jump();
    do_tick();
    @(negedge clk) cmd_word = 32'h4;  // edge while airborne, then kept held through landing
    for (int t = 2; t <= 26; t++) do_tick();
    checks++;
    if (pos_y !== 10'd400 || motion_state !== IDLE) begin
      errors++; $display("FAIL air_edge_land: y=%0d st=%0d want 400 0", pos_y, motion_state);
    end
    for (int t = 0; t < 3; t++) do_tick();
    checks++;
    if (pos_y !== 10'd400 || motion_state !== IDLE) begin
      errors++; $display("FAIL held_no_rejump: y=%0d st=%0d want 400 0", pos_y, motion_state);
    end
    @(negedge clk) cmd_word = 32'h0;
  endtask

  task automatic test_air_pulse();
    pulse_jump();
    for (int t = 1; t <= 5; t++) do_tick();
    pulse_jump();
    for (int t = 6; t <= 25; t++) do_tick();
    checks++;
    if (pos_y !== 10'd388 || motion_state !== AIR) begin
      errors++; $display("FAIL air_pulse_t25: y=%0d st=%0d want 388 2", pos_y, motion_state);
    end
    do_tick();
    checks++;
    if (pos_y !== 10'd400 || motion_state !== IDLE) begin
      errors++; $display("FAIL air_pulse_land: y=%0d st=%0d want 400 0", pos_y, motion_state);
    end
    for (int t = 0; t < 2; t++) do_tick();
    checks++;
    if (motion_state !== IDLE || pos_y !== 10'd400) begin
      errors++; $display("FAIL no_second_jump: y=%0d st=%0d want 400 0", pos_y, motion_state);
    end
  endtask

  task automatic test_mid_reposition();
    pulse_jump();
    @(negedge clk) cmd_word = 32'h2;
    for (int t = 1; t <= 5; t++) do_tick();
    checks++;
    if (pos_y !== 10'd358 || pos_x !== 10'd74 || motion_state !== AIR) begin
      errors++;
      $display("FAIL air_walk: y=%0d x=%0d st=%0d want 358 74 2", pos_y, pos_x, motion_state);
    end
    @(negedge clk) cmd_word = 32'hA;
    do_tick();
    checks++;
    if (pos_x !== 10'd64 || pos_y !== 10'd400 || motion_state !== IDLE) begin
      errors++;
      $display("FAIL mid_repos: x=%0d y=%0d st=%0d want 64 400 0", pos_x, pos_y, motion_state);
    end
    cmd_word = 32'h0;
    do_tick();
    do_tick();
    checks++;
    if (pos_y !== 10'd400 || motion_state !== IDLE) begin
      errors++; $display("FAIL repos_after: y=%0d st=%0d want 400 0", pos_y, motion_state);
    end
  endtask

  task automatic test_async_reset();
    pulse_jump();
    @(negedge clk) cmd_word = 32'h1;
    for (int t = 1; t <= 5; t++) do_tick();
    checks++;
    if (pos_y !== 10'd358 || pos_x !== 10'd54 || facing_left !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: y=%0d x=%0d f=%0b want 358 54 1", pos_y, pos_x, facing_left);
    end
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (pos_x !== 10'd64 || pos_y !== 10'd400 || motion_state !== IDLE ||
        facing_left !== 1'b0 || update_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: x=%0d y=%0d st=%0d f=%0b uv=%0b want 64 400 0 0 0",
               pos_x, pos_y, motion_state, facing_left, update_valid);
    end
    cmd_word = 32'h0;
    @(negedge clk) reset_n = 1'b1;
    do_tick();
    checks++;
    if (motion_state !== IDLE || pos_y !== 10'd400) begin
      errors++; $display("FAIL post_reset: y=%0d st=%0d want 400 0", pos_y, motion_state);
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_left_clamp();
    test_right_clamp();
    test_jump();
    test_held_jump();
    test_air_pulse();
    test_mid_reposition();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mario_motion_ctrl.md
Name: mario_motion_ctrl

Overview:
- Consumes the 32-bit command word driven by the Nios-written PIO output register (out_port) and turns it into sprite motion for the Mario character.
- Evaluates horizontal walking and jump/gravity physics once per video frame (frame_tick) and presents registered pos_x/pos_y/facing/state to the sprite renderer.
- Sits between the PIO control register and the VGA sprite drawing logic.

Parameters:
- X_MIN, 0, leftmost legal pos_x
- X_MAX, 608, rightmost legal pos_x (640 minus 32-px sprite)
- X_START, 64, pos_x after reset or reposition
- Y_GROUND, 400, ground-level pos_y (screen y grows downward)
- STEP_X, 2, horizontal pixels moved per frame while walking
- JUMP_V, 12, initial upward velocity (px/frame); also the maximum fall speed
- GRAVITY, 1, velocity decrement per frame while airborne

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_word  in  32  command from the PIO: [0] left, [1] right, [2] jump, [3] reposition, [31:4] reserved (ignored)
- frame_tick  in  1  one-cycle pulse per frame (vsync start)
- pos_x  out  10  sprite x, unsigned
- pos_y  out  10  sprite y, unsigned
- facing_left  out  1  1 = sprite faces left
- motion_state  out  2  0 IDLE, 1 WALK, 2 AIR
- update_valid  out  1  one-cycle pulse: new position is available

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk.
- Reset values:
  - pos_x = X_START, pos_y = Y_GROUND
  - facing_left = 0, motion_state = IDLE, update_valid = 0
  - internal vy = 0, cmd_q = 0, jump_req = 0
- cmd_word is registered into cmd_q every cycle. All decisions use cmd_q.
- Jump request:
  - jump_req sets on a rising edge of cmd_q[2] (prev 0 -> 1).
  - A held jump bit does not retrigger.
  - A rising edge while in AIR is discarded.
  - jump_req clears when consumed at a frame_tick.
- All state updates occur only on a clk edge where frame_tick = 1. Outputs change on that edge; update_valid = 1 for exactly the following cycle.
- If frame_tick and a jump rising edge occur in the same cycle, the request is seen at the next tick, not this one.
- Per-tick evaluation, in priority order:
  1. cmd_q[3] = 1 (reposition): pos_x = X_START, pos_y = Y_GROUND, vy = 0, state = IDLE, jump_req cleared. No other updates.
  2. Horizontal move (applies in every state):
     - Only left set: pos_x = max(X_MIN, pos_x - STEP_X), facing_left = 1.
     - Only right set: pos_x = min(X_MAX, pos_x + STEP_X), facing_left = 0.
     - Both set or neither set: no move, facing unchanged.
     - Arithmetic is done in 11-bit signed to avoid wrap-around.
  3. Vertical, ground states (IDLE/WALK):
     - If jump_req: vy = JUMP_V, state = AIR. The y change starts at the next tick.
     - Otherwise: state = WALK if exactly one direction bit is set, else IDLE.
  4. Vertical, AIR:
     - new_y = pos_y - vy, computed in 12-bit signed.
     - If new_y >= Y_GROUND: pos_y = Y_GROUND, vy = 0, state = WALK/IDLE per rule 3.
     - Else if new_y < 0: pos_y = 0, vy = 0 (ceiling clamp).
     - Else: pos_y = new_y, vy = max(vy - GRAVITY, -JUMP_V).
- vy is 8-bit signed; positive means upward.
- Reserved bits [31:4] have no effect.
- No state change occurs between ticks, apart from cmd_q and jump_req tracking.
- Reset mid-jump returns everything to reset values immediately (asynchronous).

Test Plan:
- Reset, then 3 ticks with cmd_word = 0 -> pos_x = 64, pos_y = 400, motion_state = IDLE, one update_valid pulse per tick, each one cycle after frame_tick.
- cmd_word = 0x2 for 5 ticks -> pos_x = 74, facing_left = 0, motion_state = WALK. Then cmd_word = 0x3 for 2 ticks -> pos_x stays 74, motion_state = IDLE.
- cmd_word = 0x1 for 40 ticks from pos_x = 64 -> pos_x clamps at 0 after 32 ticks and stays 0, facing_left = 1.
- Pulse jump (0x4), then ticks with 0x0:
  - Tick 1 -> AIR, pos_y = 400.
  - Tick 2 -> pos_y = 388.
  - Apex pos_y = 322 at tick 13; pos_y = 322 again at tick 14.
  - Lands at tick 26 with pos_y = 400, state IDLE.
  - Holding 0x4 after landing causes no new jump.
- Jump edge while in AIR -> ignored: landing timing is unchanged and there is no second jump.
- Mid-jump cmd_word = 0x8 at a tick -> pos_x = 64, pos_y = 400, IDLE. Separately, asserting reset_n = 0 mid-jump -> outputs return to reset values asynchronously, before the next clk edge.
